// File: rtl/ami_app_rr_arbiter.sv
// Round-robin arbiter sharing one AMI channel among NUM_APPS apps, with per-app read credits
// and an in-order tag FIFO for response routing. Optional grant counters: AMI_ARB_PERF_EN.
module ami_app_credit #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_credit
);
    logic [CW-1:0] r_credit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 r_credit <= '0;
        else if (i_inc & !i_dec) r_credit <= r_credit + 1'b1;
        else if (i_dec & !i_inc) r_credit <= r_credit - 1'b1;
    end

    assign o_credit = r_credit;
endmodule

module ami_app_rr_arbiter #(
    parameter int NUM_APPS        = 4,
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 512,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TAG_DEPTH       = 32,
    localparam int AW             = $clog2(NUM_APPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_APPS-1:0]        app_req_valid,
    input  logic [NUM_APPS-1:0]        app_req_is_write,
    input  logic [NUM_APPS*ADDR_W-1:0] app_req_addr,
    input  logic [NUM_APPS*DATA_W-1:0] app_req_data,
    output logic [NUM_APPS-1:0]        app_req_ready,
    output logic                       mem_req_valid,
    output logic                       mem_req_is_write,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [DATA_W-1:0]          mem_req_data,
    output logic [AW-1:0]              mem_req_app,
    input  logic                       mem_req_ready,
    input  logic                       mem_resp_valid,
    input  logic [DATA_W-1:0]          mem_resp_data,
    output logic                       mem_resp_ready,
    output logic [NUM_APPS-1:0]        app_resp_valid,
    output logic [DATA_W-1:0]          app_resp_data,
    input  logic [NUM_APPS-1:0]        app_resp_ready,
    output logic                       err_orphan_resp,
    output logic [NUM_APPS*32-1:0]     perf_grant_count
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(TAG_DEPTH);

    logic                      r_req_valid, r_req_is_write, r_orphan;
    logic [ADDR_W-1:0]         r_req_addr;
    logic [DATA_W-1:0]         r_req_data;
    logic [AW-1:0]             r_req_app, r_rr_ptr;
    logic [TW:0]               r_wr_ptr, r_rd_ptr;
    logic [AW-1:0]             r_tag_mem [TAG_DEPTH];

    logic [NUM_APPS-1:0][CW-1:0] w_credit;
    logic [NUM_APPS-1:0]       w_elig;
    logic                      w_found, w_slot_load, w_hs, w_push, w_pop, w_empty, w_full;
    logic [AW-1:0]             w_grant, w_head;
    logic [ADDR_W-1:0]         w_sel_addr;
    logic [DATA_W-1:0]         w_sel_data;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[TW] != r_rd_ptr[TW]) && (r_wr_ptr[TW-1:0] == r_rd_ptr[TW-1:0]);
    assign w_head  = r_tag_mem[r_rd_ptr[TW-1:0]];

    // Eligibility uses registered credit/full only, so ready never loops back through a pop.
    for (genvar i = 0; i < NUM_APPS; i++) begin : g_app
        assign w_elig[i] = app_req_valid[i] &
                           (app_req_is_write[i] | ((w_credit[i] < CW'(MAX_OUTSTANDING)) & !w_full));

        ami_app_credit #(.CW(CW)) u_credit (
            .clk      (clk),
            .rst      (rst),
            .i_inc    (w_push && (w_grant == AW'(i))),
            .i_dec    (w_pop && (w_head == AW'(i))),
            .o_credit (w_credit[i])
        );
    end

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NUM_APPS; k++) begin
            if (!w_found && w_elig[AW'((int'(r_rr_ptr) + k) % NUM_APPS)]) begin
                w_found = 1'b1;
                w_grant = AW'((int'(r_rr_ptr) + k) % NUM_APPS);
            end
        end
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_APPS; i++) begin
            if (w_grant == AW'(i)) begin
                w_sel_addr = app_req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = app_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_slot_load = !r_req_valid | mem_req_ready;
    assign w_hs        = w_found & w_slot_load;
    assign w_push      = w_hs & !app_req_is_write[w_grant];
    assign w_pop       = mem_resp_valid & !w_empty & app_resp_ready[w_head];

    always_comb begin
        app_req_ready = '0;
        if (w_hs) app_req_ready[w_grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_valid    <= 1'b0;
            r_req_is_write <= 1'b0;
            r_req_addr     <= '0;
            r_req_data     <= '0;
            r_req_app      <= '0;
            r_rr_ptr       <= '0;
        end else if (w_hs) begin
            r_req_valid    <= 1'b1;
            r_req_is_write <= app_req_is_write[w_grant];
            r_req_addr     <= w_sel_addr;
            r_req_data     <= w_sel_data;
            r_req_app      <= w_grant;
            r_rr_ptr       <= (w_grant == AW'(NUM_APPS-1)) ? '0 : w_grant + 1'b1;
        end else if (mem_req_ready) begin
            r_req_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (mem_resp_valid & w_empty) r_orphan <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_tag_mem[r_wr_ptr[TW-1:0]] <= w_grant;
    end

    always_comb begin
        app_resp_valid = '0;
        if (mem_resp_valid & !w_empty) app_resp_valid[w_head] = 1'b1;
    end

    assign mem_resp_ready   = !w_empty & app_resp_ready[w_head];
    assign app_resp_data    = mem_resp_data;
    assign err_orphan_resp  = r_orphan;
    assign mem_req_valid    = r_req_valid;
    assign mem_req_is_write = r_req_is_write;
    assign mem_req_addr     = r_req_addr;
    assign mem_req_data     = r_req_data;
    assign mem_req_app      = r_req_app;

`ifdef AMI_ARB_PERF_EN
    logic [NUM_APPS-1:0][31:0] r_perf;

    for (genvar i = 0; i < NUM_APPS; i++) begin : g_perf
        always_ff @(posedge clk or posedge rst) begin
            if (rst) r_perf[i] <= '0;
            else if (w_hs && (w_grant == AW'(i)) && (r_perf[i] != 32'hFFFF_FFFF))
                r_perf[i] <= r_perf[i] + 1'b1;
        end
    end

    assign perf_grant_count = r_perf;
`else
    assign perf_grant_count = '0;
`endif
endmodule

// File: tb/tb_ami_app_rr_arbiter.sv
// Bench for ami_app_rr_arbiter: vector table plus hand sequences; outgoing requests checked
// against a queue of expected {app, type, addr, data} pushed when a grant is observed.
module tb_ami_app_rr_arbiter;
    localparam int N = 4, AWD = 32, DW = 32;

    logic            clk = 1'b0, rst = 1'b1;
    logic [N-1:0]    app_req_valid = '0, app_req_is_write = '0, app_req_ready;
    logic [N*AWD-1:0] app_req_addr = '0;
    logic [N*DW-1:0] app_req_data = '0;
    logic            mem_req_valid, mem_req_is_write, mem_req_ready = 1'b0;
    logic [AWD-1:0]  mem_req_addr;
    logic [DW-1:0]   mem_req_data, mem_resp_data = '0, app_resp_data;
    logic [1:0]      mem_req_app;
    logic            mem_resp_valid = 1'b0, mem_resp_ready, err_orphan_resp;
    logic [N-1:0]    app_resp_valid, app_resp_ready = '0;
    logic [N*32-1:0] perf_grant_count;

    ami_app_rr_arbiter #(.NUM_APPS(N), .ADDR_W(AWD), .DATA_W(DW), .MAX_OUTSTANDING(8), .TAG_DEPTH(32)) dut (
        .clk(clk), .rst(rst),
        .app_req_valid(app_req_valid), .app_req_is_write(app_req_is_write),
        .app_req_addr(app_req_addr), .app_req_data(app_req_data), .app_req_ready(app_req_ready),
        .mem_req_valid(mem_req_valid), .mem_req_is_write(mem_req_is_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_app(mem_req_app),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_ready(mem_resp_ready),
        .app_resp_valid(app_resp_valid), .app_resp_data(app_resp_data), .app_resp_ready(app_resp_ready),
        .err_orphan_resp(err_orphan_resp), .perf_grant_count(perf_grant_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] app; logic wr; logic [31:0] addr; logic [31:0] data; } exp_t;
    typedef struct { logic [3:0] valid; logic [3:0] wr; logic [3:0] exp_ready; } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t tbl[8];
    int   total = 0, bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task set_lanes;
        for (int i = 0; i < N; i++) begin
            app_req_addr[i*AWD +: AWD] = 32'h1000 + 32'(i * 16);
            app_req_data[i*DW +: DW]   = 32'hD000 + 32'(i);
        end
    endtask

    task push_exp(input int a);
        sbq.push_back('{2'(a), app_req_is_write[a], app_req_addr[a*AWD +: AWD], app_req_data[a*DW +: DW]});
    endtask

    task do_reset;
        chk("sb_leftover", 128'(sbq.size()), 0);
        sbq.delete();
        rst = 1'b1;
        app_req_valid = '0; app_req_is_write = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_data = '0; app_resp_ready = '0;
        set_lanes();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Requests leaving the channel are compared against the expected queue.
    always @(negedge clk) begin
        if (!rst && mem_req_valid && mem_req_ready) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_unexpected: got app %0d addr %0h, expected no request", mem_req_app, mem_req_addr);
            end else begin
                mon_e = sbq.pop_front();
                chk("req_out", {mem_req_app, mem_req_is_write, mem_req_addr, mem_req_data},
                    {mon_e.app, mon_e.wr, mon_e.addr, mon_e.data});
            end
        end
    end

    initial begin
        int acc;
        tbl[0] = '{4'b1111, 4'b1111, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0000, 4'b0010};
        tbl[2] = '{4'b0001, 4'b0001, 4'b0001};
        tbl[3] = '{4'b0000, 4'b0000, 4'b0000};
        tbl[4] = '{4'b1001, 4'b0000, 4'b1000};
        tbl[5] = '{4'b0110, 4'b0100, 4'b0010};
        tbl[6] = '{4'b0110, 4'b0000, 4'b0100};
        tbl[7] = '{4'b0011, 4'b0000, 4'b0001};

        // reset state
        do_reset();
        #3;
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_req_fields", {mem_req_app, mem_req_is_write, mem_req_addr, mem_req_data}, 0);
        chk("rst_mem_resp_ready", mem_resp_ready, 0);
        chk("rst_app_resp_valid", app_resp_valid, 0);
        chk("rst_err", err_orphan_resp, 0);
        chk("rst_perf", perf_grant_count, 0);
        chk("rst_app_req_ready", app_req_ready, 0);
        tick();

        // vector table: round-robin pointer walk
        do_reset();
        mem_req_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            app_req_valid = tbl[v].valid;
            app_req_is_write = tbl[v].wr;
            #3;
            chk($sformatf("tbl%0d_ready", v), app_req_ready, tbl[v].exp_ready);
            for (int i = 0; i < N; i++) if (tbl[v].exp_ready[i]) push_exp(i);
            tick();
        end
        app_req_valid = '0;
        tick();

        // fairness: continuous reads from all apps
        do_reset();
        mem_req_ready = 1'b1;
        app_req_valid = 4'hF;
        for (int c = 0; c < 12; c++) begin
            #3;
            chk($sformatf("fair%0d_ready", c), app_req_ready, 4'b0001 << (c % 4));
            push_exp(c % 4);
            tick();
        end
        app_req_valid = '0;
        tick();

        // credit cap on app 1
        do_reset();
        mem_req_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            app_req_valid = 4'b0010;
            #3;
            if (app_req_ready[1]) begin acc++; push_exp(1); end
            tick();
        end
        chk("cap_accepted", 128'(acc), 8);
        #3;
        chk("cap_ready_low", app_req_ready[1], 0);
        app_req_valid = '0;
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h55; app_resp_ready = 4'b0010;
        #3;
        chk("cap_resp_valid", app_resp_valid, 4'b0010);
        chk("cap_resp_ready", mem_resp_ready, 1);
        chk("cap_resp_data", app_resp_data, 32'h55);
        tick();
        mem_resp_valid = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            app_req_valid = 4'b0010;
            #3;
            if (app_req_ready[1]) begin acc++; push_exp(1); end
            tick();
        end
        chk("cap_refill", 128'(acc), 1);
        app_req_valid = '0;
        tick();

        // routing through the tag FIFO, with a stall on app 0
        do_reset();
        mem_req_ready = 1'b1;
        app_req_valid = 4'b0100; #3; chk("rt_ready2", app_req_ready, 4'b0100); push_exp(2); tick();
        app_req_valid = 4'b0001; #3; chk("rt_ready0", app_req_ready, 4'b0001); push_exp(0); tick();
        app_req_valid = 4'b1000; #3; chk("rt_ready3", app_req_ready, 4'b1000); push_exp(3); tick();
        app_req_valid = '0;
        tick();
        mem_resp_valid = 1'b1; app_resp_ready = 4'hF; mem_resp_data = 32'hA;
        #3;
        chk("rt_a", {app_resp_valid, mem_resp_ready, app_resp_data}, {4'b0100, 1'b1, 32'hA});
        tick();
        mem_resp_data = 32'hB; app_resp_ready = 4'b1110;
        #3;
        chk("rt_b_stall", {app_resp_valid, mem_resp_ready}, {4'b0001, 1'b0});
        tick();
        app_resp_ready = 4'hF;
        #3;
        chk("rt_b", {app_resp_valid, mem_resp_ready, app_resp_data}, {4'b0001, 1'b1, 32'hB});
        tick();
        mem_resp_data = 32'hC;
        #3;
        chk("rt_c", {app_resp_valid, mem_resp_ready, app_resp_data}, {4'b1000, 1'b1, 32'hC});
        tick();
        mem_resp_valid = 1'b0;
        #3;
        chk("rt_empty", {app_resp_valid, mem_resp_ready, err_orphan_resp}, 0);
        tick();

        // backpressure: held write, no new handshakes
        do_reset();
        app_req_valid = 4'b0001; app_req_is_write = 4'b0001;
        app_req_addr[31:0] = 32'h40; app_req_data[31:0] = 32'h99;
        #3;
        chk("bp_first_ready", app_req_ready, 4'b0001);
        push_exp(0);
        tick();
        app_req_addr[31:0] = 32'h80;
        for (int c = 0; c < 5; c++) begin
            #3;
            chk($sformatf("bp_hold%0d", c), {app_req_ready, mem_req_valid, mem_req_is_write, mem_req_addr},
                {4'b0000, 1'b1, 1'b1, 32'h40});
            tick();
        end
        mem_req_ready = 1'b1; app_req_valid = '0;
        #3;
        chk("bp_release", {mem_req_valid, mem_req_addr}, {1'b1, 32'h40});
        tick();
        #3;
        chk("bp_done", mem_req_valid, 0);
        tick();

        // orphan response and async reset clear
        do_reset();
        mem_resp_valid = 1'b1; app_resp_ready = 4'hF;
        #3;
        chk("orph_ready", {mem_resp_ready, app_resp_valid, err_orphan_resp}, 0);
        tick();
        chk("orph_set", err_orphan_resp, 1);
        mem_resp_valid = 1'b0;
        tick();
        chk("orph_sticky", err_orphan_resp, 1);
        #2 rst = 1'b1;
        #1;
        chk("orph_async_clr", err_orphan_resp, 0);
        tick();
        rst = 1'b0;

        // grant counters: 100 writes from app 3
        do_reset();
        mem_req_ready = 1'b1;
        acc = 0;
        app_req_is_write = 4'b1000;
        for (int c = 0; c < 100; c++) begin
            app_req_valid = 4'b1000;
            #3;
            if (app_req_ready[3]) begin acc++; push_exp(3); end
            tick();
        end
        app_req_valid = '0;
        tick();
        chk("perf_grants", 128'(acc), 100);
`ifdef AMI_ARB_PERF_EN
        chk("perf_app3", perf_grant_count[96 +: 32], 100);
`else
        chk("perf_app3", perf_grant_count[96 +: 32], 0);
`endif
        chk("perf_others", perf_grant_count[95:0], 0);
        chk("sb_final", 128'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
